fp_accumulator: RTL and testbench



---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_norm.sv | 40 ++++
 rtl/fp_accumulator.sv | 194 +++++++++++++++++++
 tb/tb_fp_accumulator.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 constants, field struct and accumulator FSM states.
package fp_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN_W   = 23;
  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_OUT
  } state_t;

  // Significand with the hidden one restored; exponent field 0 reads as zero.
  function automatic logic [FP_MAN_W:0] full_man(input fp32_t f);
    return (f.exp == '0) ? '0 : {1'b1, f.man};
  endfunction

endpackage

// File: rtl/fp_norm.sv
// Normaliser for the accumulator: resolves a carry-out or counts leading
// zeros, shifts the 27-bit significand (hidden bit + 23 + G/R/S) left and adjusts the exponent.
module fp_norm
  import fp_pkg::*;
(
  input  logic        [FP_MAN_W+4:0] sum_man,
  input  logic signed [9:0]          sum_exp,
  output logic        [FP_MAN_W+3:0] norm_man,
  output logic signed [9:0]          norm_exp,
  output logic                       is_zero
);

  logic [4:0] lz;
  logic       found;

  always_comb begin
    // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
    lz    = '0;
    found = 1'b0;
    for (int i = FP_MAN_W + 3; i >= 0; i--) begin
      if (!found) begin
        if (sum_man[i]) found = 1'b1;
        else            lz    = lz + 5'd1;
      end
    end
  end

  always_comb begin
    is_zero = (sum_man == '0);
    if (sum_man[FP_MAN_W+4]) begin
      // Carry out: the dropped bit folds into sticky.
      norm_man = {sum_man[FP_MAN_W+4:2], sum_man[1] | sum_man[0]};
      norm_exp = sum_exp + 10'sd1;
    end else begin
      norm_man = sum_man[FP_MAN_W+3:0] << lz;
      norm_exp = sum_exp - $signed({5'b00000, lz});
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Sequential binary32 accumulator: one term per four cycles through align/add/normalise.
// Build option FP_ACC_ROUND_EN selects round-to-nearest-even; otherwise results truncate.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_cnt
);

  state_t            state, state_n;
  fp32_t             acc, term, inf_val, acc_n;
  logic [CNT_W-1:0]  cnt;
  logic              last_q, inf_q;

  logic              big_sign, sml_sign;
  logic [7:0]        big_exp;
  logic [26:0]       big_man, sml_man;
  logic              res_sign;
  logic [7:0]        res_exp;
  logic [27:0]       res_man;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    case (state)
      S_IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_n = S_ALIGN;
      end
      S_ALIGN: state_n = S_ADD;
      S_ADD:   state_n = S_NORM;
      S_NORM:  state_n = last_q ? S_OUT : S_IDLE;
      S_OUT: begin
        out_vld = 1'b1;
        if (out_rdy) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------- align ----------------
  fp32_t       op_big, op_sml;
  logic [7:0]  diff;
  logic [26:0] sml_raw, sml_mask, sml_shift;
  logic        sticky;

  always_comb begin
    if (acc.exp >= term.exp) begin
      op_big = acc;
      op_sml = term;
    end else begin
      op_big = term;
      op_sml = acc;
    end
    diff     = op_big.exp - op_sml.exp;
    sml_raw  = {full_man(op_sml), 3'b000};
    sml_mask = ~({27{1'b1}} << diff);
    if (diff >= 8'd27) begin
      sml_shift = '0;
      sticky    = |sml_raw;
    end else begin
      sml_shift = sml_raw >> diff;
      sticky    = |(sml_raw & sml_mask);
    end
  end

  // ---------------- add ----------------
  logic [27:0] add_man;
  logic        add_sign;

  always_comb begin
    if (big_sign == sml_sign) begin
      add_man  = {1'b0, big_man} + {1'b0, sml_man};
      add_sign = big_sign;
    end else if (big_man > sml_man) begin
      add_man  = {1'b0, big_man - sml_man};
      add_sign = big_sign;
    end else if (big_man < sml_man) begin
      add_man  = {1'b0, sml_man - big_man};
      add_sign = sml_sign;
    end else begin
      add_man  = '0;
      add_sign = 1'b0;
    end
  end

  // ---------------- normalise / round ----------------
  logic signed [9:0] res_exp_s, norm_exp, exp_r;
  logic [26:0]       norm_man;
  logic [22:0]       frac;
  logic              is_zero;

  assign res_exp_s = $signed({2'b00, res_exp});

  fp_norm u_norm (
    .sum_man  (res_man),
    .sum_exp  (res_exp_s),
    .norm_man (norm_man),
    .norm_exp (norm_exp),
    .is_zero  (is_zero)
  );

`ifdef FP_ACC_ROUND_EN
  logic round_up, round_carry;

  always_comb begin
    round_up = norm_man[2] & (norm_man[3] | norm_man[1] | norm_man[0]);
    {round_carry, frac} = {1'b0, norm_man[25:3]} + {23'd0, round_up};
    exp_r = norm_exp + $signed({9'd0, round_carry});
  end
`else
  logic grs_unused;

  assign grs_unused = ^norm_man[2:0];
  assign frac       = norm_man[25:3];
  assign exp_r      = norm_exp;
`endif

  always_comb begin
    if (inf_q)                         acc_n = inf_val;
    else if (is_zero || norm_exp <= 10'sd0) acc_n = FP_ZERO;
    else if (exp_r >= 10'(FP_EXP_MAX)) acc_n = {res_sign, FP_POS_INF[30:0]};
    else                               acc_n = {res_sign, exp_r[7:0], frac};
  end

  // ---------------- state with reset ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= FP_ZERO;
      cnt      <= '0;
      out_data <= '0;
      out_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_vld && cnt != '1) cnt <= cnt + CNT_W'(1);
        S_NORM: begin
          acc <= acc_n;
          if (last_q) begin
            out_data <= acc_n;
            out_cnt  <= cnt;
          end
        end
        S_OUT: if (out_rdy) begin
          acc <= FP_ZERO;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: pipeline registers are always written before being read, so they carry no reset.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (in_vld) begin
        term   <= in_data;
        last_q <= in_last;
      end
      S_ALIGN: begin
        big_sign <= op_big.sign;
        big_exp  <= op_big.exp;
        big_man  <= {full_man(op_big), 3'b000};
        sml_sign <= op_sml.sign;
        sml_man  <= sml_shift | {26'd0, sticky};
        inf_q    <= (acc.exp == 8'(FP_EXP_MAX)) || (term.exp == 8'(FP_EXP_MAX));
        inf_val  <= (acc.exp == 8'(FP_EXP_MAX)) ? acc : {term.sign, FP_POS_INF[30:0]};
      end
      S_ADD: begin
        res_sign <= add_sign;
        res_exp  <= big_exp;
        res_man  <= add_man;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator: exact-arithmetic reference model plus directed literals.
module tb_fp_accumulator;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk, rst;
  logic             in_vld, in_rdy, in_last;
  logic [31:0]      in_data;
  logic             out_vld, out_rdy;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_cnt;

  fp_accumulator #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_cnt  (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Exact sum of two binary32 values, then truncated (or RNE-rounded) to 24 bits.
  // Values are integers in units of 2^-36 of the larger operand's ulp; an operand
  // more than 36 binades smaller only matters as a tiny non-zero remainder.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    longint ma, mb, va, vb, s, mag, m, rem, half;
    int     ea, eb, emax, e, p;
    logic   sign;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return {b[31], 8'hFF, 23'h0};
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    ma   = (ea == 0) ? 0 : longint'({1'b1, a[22:0]});
    mb   = (eb == 0) ? 0 : longint'({1'b1, b[22:0]});
    emax = (ea > eb) ? ea : eb;
    va   = (emax - ea <= 36) ? (ma <<< (36 - (emax - ea))) : ((ma != 0) ? 1 : 0);
    vb   = (emax - eb <= 36) ? (mb <<< (36 - (emax - eb))) : ((mb != 0) ? 1 : 0);
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    s = va + vb;
    if (s == 0) return 32'h0;
    sign = (s < 0);
    mag  = sign ? -s : s;
    p = 0;
    for (int i = 0; i < 62; i++) if (((mag >> i) & 1) != 0) p = i;
    e = emax + p - 59;
    if (e <= 0)   return 32'h0;
    if (e >= 255) return {sign, 8'hFF, 23'h0};
    if (p >= 23) begin
      m    = mag >> (p - 23);
      rem  = mag & ((64'sd1 <<< (p - 23)) - 1);
      half = (p >= 24) ? (64'sd1 <<< (p - 24)) : 0;
    end else begin
      m    = mag <<< (23 - p);
      rem  = 0;
      half = 0;
    end
`ifdef FP_ACC_ROUND_EN
    if (p >= 24 && (rem > half || (rem == half && (m & 1) != 0))) begin
      m = m + 1;
      if (m == (64'sd1 <<< 24)) begin
        m = m >> 1;
        e = e + 1;
        if (e >= 255) return {sign, 8'hFF, 23'h0};
      end
    end
`endif
    return {sign, e[7:0], m[22:0]};
  endfunction

  typedef struct {
    logic [31:0] data;
    int          cnt;
    int          due;
  } res_t;

  res_t        exp_q[$];
  logic [31:0] m_acc = 32'h0;
  int          m_cnt = 0;
  int          busy_until = 0;
  int          cyc = 0;
  int          n_results = 0;
  logic [31:0] last_data;
  int          last_cnt;
  bit          rdy_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    bit exp_vld;
    if (rst) begin
      exp_q.delete();
      m_acc      = 32'h0;
      m_cnt      = 0;
      busy_until = 0;
    end else begin
      exp_vld = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
      check("out_vld", 32'(out_vld), 32'(exp_vld));
      check("in_rdy", 32'(in_rdy), 32'((exp_q.size() == 0) && (cyc >= busy_until)));
      if (out_vld && exp_vld) begin
        check("out_data", out_data, exp_q[0].data);
        check("out_cnt", 32'(out_cnt), 32'(exp_q[0].cnt));
        if (out_rdy) begin
          last_data = out_data;
          last_cnt  = int'(out_cnt);
          n_results++;
          void'(exp_q.pop_front());
        end
      end
      if (in_vld && in_rdy) begin
        m_acc      = model_add(m_acc, in_data);
        m_cnt      = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        busy_until = cyc + 4;
        if (in_last) begin
          exp_q.push_back('{data: m_acc, cnt: m_cnt, due: cyc + 4});
          m_acc = 32'h0;
          m_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bit accepted = 0;
    in_vld  = 1'b1;
    in_data = d;
    in_last = last;
    for (int i = 0; i < 50; i++) begin
      accepted = in_rdy;
      tick();
      if (accepted) break;
    end
    if (!accepted) check("accept_timeout", 32'(accepted), 32'd1);
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_result();
    int target = n_results + 1;
    for (int i = 0; i < 300 && n_results < target; i++) tick();
    if (n_results < target) check("result_timeout", 32'(n_results), 32'(target));
  endtask

  task automatic sum2(input logic [31:0] a, input logic [31:0] b);
    send(a, 1'b0);
    send(b, 1'b1);
    wait_result();
  endtask

  function automatic logic [31:0] rand_term();
    int          r = $urandom_range(0, 19);
    logic [7:0]  e;
    if (r == 0)      e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else if (r == 2) e = 8'($urandom_range(250, 254));
    else             e = 8'($urandom_range(115, 140));
    return {1'($urandom_range(0, 1)), e, (e == 8'hFF) ? 23'h0 : 23'($urandom)};
  endfunction

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_data = '0; in_last = 1'b0; out_rdy = 1'b1;
    tick();
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    sum2(32'h3F800000, 32'h40000000);
    check("one_plus_two", last_data, 32'h40400000);
    check("one_plus_two_cnt", 32'(last_cnt), 32'd2);

    sum2(32'h3F800000, 32'hBF800000);
    check("cancel", last_data, 32'h00000000);
    check("cancel_cnt", 32'(last_cnt), 32'd2);

    sum2(32'h7F7FFFFF, 32'h7F7FFFFF);
    check("overflow", last_data, 32'h7F800000);

    // Backpressure: result must stay put while out_rdy is low.
    out_rdy = 1'b0;
    send(32'h3F800000, 1'b1);
    for (int i = 0; i < 10 && !out_vld; i++) tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_vld", 32'(out_vld), 32'd1);
      check("hold_data", out_data, 32'h3F800000);
      check("hold_in_rdy", 32'(in_rdy), 32'd0);
      tick();
    end
    out_rdy = 1'b1;
    tick();
    check("in_rdy_after_out", 32'(in_rdy), 32'd1);

    // Reset while the first term sits in the align stage.
    send(32'h3F800000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_vld", 32'(out_vld), 32'd0);
    check("midrst_in_rdy", 32'(in_rdy), 32'd1);
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_out_cnt", 32'(out_cnt), 32'd0);
    send(32'h40000000, 1'b1);
    wait_result();
    check("after_rst", last_data, 32'h40000000);
    check("after_rst_cnt", 32'(last_cnt), 32'd1);

    sum2(32'h3F800000, 32'h33C00000);
`ifdef FP_ACC_ROUND_EN
    check("round", last_data, 32'h3F800001);
`else
    check("trunc", last_data, 32'h3F800000);
`endif

    send(32'h00400000, 1'b1);
    wait_result();
    check("exp0_single", last_data, 32'h00000000);
    send(32'hC0A00000, 1'b1);
    wait_result();
    check("single_term", last_data, 32'hC0A00000);

    send(32'h3F800000, 1'b0);
    send(32'hFF800000, 1'b0);
    send(32'h7F800000, 1'b1);
    wait_result();
    check("inf_sticky", last_data, 32'hFF800000);
    check("inf_cnt", 32'(last_cnt), 32'd3);

    for (int i = 0; i < 18; i++) send(32'h3F800000, 1'(i == 17));
    wait_result();
    check("eighteen", last_data, 32'h41900000);
    check("cnt_saturate", 32'(last_cnt), 32'(CNT_MAX));

    rdy_rand = 1;
    for (int s = 0; s < 60; s++) begin
      int n = $urandom_range(1, 5);
      for (int t = 0; t < n; t++) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        send(rand_term(), 1'(t == n - 1));
      end
      wait_result();
    end
    rdy_rand = 0;
    out_rdy  = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
